mem_arbiter: RTL and testbench

Arbitrates the instruction cache and data cache line-fill/write-back requests onto the single physical memory port. Converts each 256-bit cache-line transfer into a 4-beat, 64-bit burst on pmem. Sits between `instcache`/`datacache` (upstream) and physical memory (downstream) inside `mp3`.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_burst_adaptor.sv | 60 ++++++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encoding for the cache-to-pmem arbiter.
// One 256-bit cache line moves as four 64-bit bursts beats.
package mem_arbiter_pkg;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int CNT_W  = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE,
    DONE
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_burst_adaptor.sv
// Line buffer and beat counter: turns one 256-bit line transfer into a
// four-beat 64-bit pmem burst, in either direction.
module mem_arbiter_burst_adaptor
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic              active,
  input  logic [31:0]       addr,
  input  logic [LINE_W-1:0] line_in,
  input  logic              pmem_resp,
  input  logic [BEAT_W-1:0] pmem_rdata,
  output logic [LINE_W-1:0] line_out,
  output logic [31:0]       pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  output logic              done
);
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              rw_q, rw_d;

  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    rw_d   = rw_q;
    if (start) begin
      addr_d = addr & ~32'h1F;
      rw_d   = rw;
      cnt_d  = '0;
      if (rw) line_d = line_in;
    end else if (active && pmem_resp) begin
      // Read beats land in the slot selected by the counter; writes only advance it.
      if (!rw_q) line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = pmem_rdata;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
      rw_q   <= 1'b0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      rw_q   <= rw_d;
    end
  end

  assign line_out     = line_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = line_q[int'(cnt_q)*BEAT_W +: BEAT_W];
  assign done         = active && pmem_resp && (cnt_q == CNT_W'(BEATS - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Grants the single pmem port to icache or dcache (dcache write > dcache
// read > icache read) and routes the completion pulse back to the winner.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  arb_state_t        state_q, state_d;
  logic              grant_d_q, grant_d_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic              start;
  logic              active;
  logic              burst_done;
  logic [31:0]       start_addr;
  logic [LINE_W-1:0] line_out;

  assign start_addr = (d_pmem_write || d_pmem_read) ? d_pmem_address : i_pmem_address;
  assign pmem_read  = (state_q == I_READ) || (state_q == D_READ);
  assign pmem_write = (state_q == D_WRITE);
  assign active     = pmem_read || pmem_write;

  always_comb begin
    state_d   = state_q;
    grant_d_d = grant_d_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_pmem_write) begin
          state_d   = D_WRITE;
          grant_d_d = 1'b1;
          start     = 1'b1;
        end else if (d_pmem_read) begin
          state_d   = D_READ;
          grant_d_d = 1'b1;
          start     = 1'b1;
        end else if (i_pmem_read) begin
          state_d   = I_READ;
          grant_d_d = 1'b0;
          start     = 1'b1;
        end
      end
      I_READ, D_READ, D_WRITE: begin
        if (burst_done) begin
          state_d  = DONE;
          i_resp_d = !grant_d_q;
          d_resp_d = grant_d_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_d_q <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_d_q <= grant_d_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
    end
  end

  mem_arbiter_burst_adaptor u_burst (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rw           (d_pmem_write),
    .active       (active),
    .addr         (start_addr),
    .line_in      (d_pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .line_out     (line_out),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .done         (burst_done)
  );

  assign i_pmem_rdata = line_out;
  assign d_pmem_rdata = line_out;
  assign i_pmem_resp  = i_resp_q;
  assign d_pmem_resp  = d_resp_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a scripted pmem responder plus a
// monitor that pops the expected line on every cache resp pulse.
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_d;
    logic [255:0] line;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   n_i_resp = 0;
  int   n_d_resp = 0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Every resp pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (i_pmem_resp || d_pmem_resp)) begin
      if (i_pmem_resp) n_i_resp++;
      if (d_pmem_resp) n_d_resp++;
      if (sb.size() == 0) begin
        check_eq("unexpected_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
      end else begin
        mon_e = sb.pop_front();
        check_eq("sb_i_resp", i_pmem_resp, !mon_e.is_d);
        check_eq("sb_d_resp", d_pmem_resp, mon_e.is_d);
        check_eq("sb_i_rdata", i_pmem_rdata, mon_e.line);
        check_eq("sb_d_rdata", d_pmem_rdata, mon_e.line);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // Serve one burst from the negedge after the request; returns at the DONE negedge.
  task automatic serve_burst(input string tag, input logic [31:0] exp_addr, input bit is_wr,
                             input logic [255:0] line, input int d0, input int d1,
                             input int d2, input int d3, output int waited);
    int dly[4];
    dly = '{d0, d1, d2, d3};
    waited = 0;
    while (!(pmem_read || pmem_write) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_start"}, pmem_read || pmem_write, 1'b1);
    if (!(pmem_read || pmem_write)) return;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s <= dly[b]; s++) begin
        check_eq({tag, "_rd"}, pmem_read, !is_wr);
        check_eq({tag, "_wr"}, pmem_write, is_wr);
        check_eq({tag, "_addr"}, pmem_address, exp_addr);
        if (is_wr) check_eq({tag, "_wdata"}, pmem_wdata, line[b*64 +: 64]);
        if (s == dly[b]) begin
          pmem_rdata = line[b*64 +: 64];
          pmem_resp  = 1'b1;
        end else begin
          pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
          pmem_resp  = 1'b0;
        end
        @(negedge clk);
      end
    end
    pmem_resp = 1'b0;
    check_eq({tag, "_done_rd"}, pmem_read, 1'b0);
    check_eq({tag, "_done_wr"}, pmem_write, 1'b0);
  endtask

  function automatic logic [255:0] word_line(input int base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'(base + k);
    return l;
  endfunction

  logic [255:0] fill_line, wb_line, simd_line, simi_line, stall_line, post_line, un_line;
  int w;

  initial begin
    rst = 1'b1;
    i_pmem_read = 0; i_pmem_address = 0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = 0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    fill_line  = {64'h4444444444444444, 64'h3333333333333333,
                  64'h2222222222222222, 64'h1111111111111111};
    wb_line    = word_line(0);
    simd_line  = word_line(32'h100);
    simi_line  = word_line(32'h200);
    stall_line = word_line(32'h300);
    post_line  = word_line(32'h400);
    un_line    = word_line(32'h500);
    repeat (3) @(negedge clk);
    check_eq("rst_pmem_read", pmem_read, 1'b0);
    check_eq("rst_pmem_write", pmem_write, 1'b0);
    check_eq("rst_pmem_address", pmem_address, 32'h0);
    check_eq("rst_pmem_wdata", pmem_wdata, 64'h0);
    check_eq("rst_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    check_eq("rst_rdata", i_pmem_rdata, 256'h0);
    rst = 1'b0;
    @(negedge clk);

    // icache fill, back-to-back beats
    sb.push_back('{is_d: 1'b0, line: fill_line});
    i_pmem_address = 32'h60; i_pmem_read = 1'b1;
    @(negedge clk);
    check_eq("fill_latency", pmem_read, 1'b1);
    serve_burst("fill", 32'h60, 1'b0, fill_line, 0, 0, 0, 0, w);
    check_eq("fill_wait", w, 0);
    check_eq("fill_i_resp", i_pmem_resp, 1'b1);
    check_eq("fill_d_resp", d_pmem_resp, 1'b0);
    i_pmem_read = 1'b0;
    @(negedge clk);
    check_eq("fill_idle", pmem_read, 1'b0);
    check_eq("fill_resp_once", i_pmem_resp, 1'b0);
    check_eq("fill_hold", i_pmem_rdata, fill_line);

    // dcache write-back; upstream inputs scrambled mid-burst
    sb.push_back('{is_d: 1'b1, line: wb_line});
    d_pmem_address = 32'h100; d_pmem_wdata = wb_line; d_pmem_write = 1'b1;
    @(negedge clk);
    d_pmem_address = 32'hFFFF_FFE0; d_pmem_wdata = {8{32'hA5A5_A5A5}};
    serve_burst("wb", 32'h100, 1'b1, wb_line, 0, 0, 0, 0, w);
    check_eq("wb_d_resp", d_pmem_resp, 1'b1);
    check_eq("wb_i_resp", i_pmem_resp, 1'b0);
    d_pmem_write = 1'b0;
    @(negedge clk);

    // simultaneous icache/dcache reads: dcache first, one IDLE, then icache
    sb.push_back('{is_d: 1'b1, line: simd_line});
    sb.push_back('{is_d: 1'b0, line: simi_line});
    d_pmem_address = 32'h80; i_pmem_address = 32'h1A0;
    d_pmem_read = 1'b1; i_pmem_read = 1'b1;
    @(negedge clk);
    serve_burst("sim_d", 32'h80, 1'b0, simd_line, 0, 0, 0, 0, w);
    check_eq("sim_d_resp", d_pmem_resp, 1'b1);
    check_eq("sim_d_iresp", i_pmem_resp, 1'b0);
    d_pmem_read = 1'b0;
    @(negedge clk);
    check_eq("sim_gap", pmem_read, 1'b0);
    serve_burst("sim_i", 32'h1A0, 1'b0, simi_line, 0, 0, 0, 0, w);
    check_eq("sim_i_wait", w, 1);
    check_eq("sim_i_resp", i_pmem_resp, 1'b1);
    check_eq("sim_i_dresp", d_pmem_resp, 1'b0);
    i_pmem_read = 1'b0;
    @(negedge clk);

    // stalled beats on a dcache read
    sb.push_back('{is_d: 1'b1, line: stall_line});
    d_pmem_address = 32'h300; d_pmem_read = 1'b1;
    @(negedge clk);
    serve_burst("stall", 32'h300, 1'b0, stall_line, 0, 3, 1, 5, w);
    check_eq("stall_resp", d_pmem_resp, 1'b1);
    d_pmem_read = 1'b0;
    @(negedge clk);

    // reset after beat 2 of a dcache read: no resp, everything cleared
    d_pmem_address = 32'h240; d_pmem_read = 1'b1;
    @(negedge clk);
    check_eq("rmb_start", pmem_read, 1'b1);
    for (int b = 0; b < 2; b++) begin
      pmem_rdata = {2{32'hCAFE_0000 + 32'(b)}};
      pmem_resp  = 1'b1;
      @(negedge clk);
    end
    pmem_resp = 1'b0; d_pmem_read = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("rmb_pmem_read", pmem_read, 1'b0);
    check_eq("rmb_pmem_write", pmem_write, 1'b0);
    check_eq("rmb_address", pmem_address, 32'h0);
    check_eq("rmb_wdata", pmem_wdata, 64'h0);
    check_eq("rmb_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    check_eq("rmb_rdata", d_pmem_rdata, 256'h0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rmb_no_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    end
    sb.push_back('{is_d: 1'b0, line: post_line});
    i_pmem_address = 32'h40; i_pmem_read = 1'b1;
    @(negedge clk);
    serve_burst("post", 32'h40, 1'b0, post_line, 0, 0, 0, 0, w);
    check_eq("post_resp", i_pmem_resp, 1'b1);
    i_pmem_read = 1'b0;
    @(negedge clk);

    // unaligned icache address
    sb.push_back('{is_d: 1'b0, line: un_line});
    i_pmem_address = 32'h1234_567C; i_pmem_read = 1'b1;
    @(negedge clk);
    serve_burst("unal", 32'h1234_5660, 1'b0, un_line, 0, 0, 0, 0, w);
    check_eq("unal_resp", i_pmem_resp, 1'b1);
    i_pmem_read = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("sb_empty", sb.size(), 0);
    check_eq("i_resp_count", n_i_resp, 4);
    check_eq("d_resp_count", n_d_resp, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
